// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge-detection core.
package sobel_pkg;

    // Control FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        LOAD    = 3'd2,
        AVAIL   = 3'd3,
        COMPUTE = 3'd4
    } state_e;

    // Signed gradient width: |G| <= 4*255 = 1020 fits in 12 bits signed.
    localparam int GRAD_W = 12;

    // Output magnitude clamp.
    localparam logic [7:0] SAT_MAX = 8'd255;

    // 3x3 kernels, row-major: index = row*3 + col.
    localparam int GX_COEF [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int GY_COEF [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    // Clamp an unsigned magnitude to the 8-bit pixel range.
    function automatic logic [7:0] saturate(input logic [GRAD_W-1:0] mag);
        logic [7:0] res;
        if (mag > GRAD_W'(SAT_MAX)) begin
            res = SAT_MAX;
        end else begin
            res = mag[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sobel_kernel3x3.sv
// Combinational 3x3 Sobel operator: |Gx| + |Gy|, saturated to 8 bits.
module sobel_kernel3x3 import sobel_pkg::*; (
    input  logic [8:0][7:0] win_i,
    output logic [7:0]      mag_o
);

    logic signed [GRAD_W-1:0] gx_s;
    logic signed [GRAD_W-1:0] gy_s;
    logic        [GRAD_W-1:0] ax_s;
    logic        [GRAD_W-1:0] ay_s;
    logic        [GRAD_W-1:0] mag_s;

    // Weighted sums over the window, absolute values, then clamp.
    always_comb begin
        gx_s = '0;
        gy_s = '0;
        for (int k = 0; k < 9; k++) begin
            gx_s = gx_s + $signed(GRAD_W'(GX_COEF[k])) * $signed(GRAD_W'(win_i[k]));
            gy_s = gy_s + $signed(GRAD_W'(GY_COEF[k])) * $signed(GRAD_W'(win_i[k]));
        end
        if (gx_s[GRAD_W-1]) begin
            ax_s = GRAD_W'(-gx_s);
        end else begin
            ax_s = GRAD_W'(gx_s);
        end
        if (gy_s[GRAD_W-1]) begin
            ay_s = GRAD_W'(-gy_s);
        end else begin
            ay_s = GRAD_W'(gy_s);
        end
        mag_s = ax_s + ay_s;
        mag_o = saturate(mag_s);
    end

endmodule

// File: rtl/sobel.sv
// Sobel core top: start handshake, frame buffer load, windowed compute, output register.
module sobel import sobel_pkg::*; #(
    parameter int KX_SIZE    = 3,
    parameter int KY_SIZE    = 3,
    parameter int IMG_X_SIZE = 3,
    parameter int IMG_Y_SIZE = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] GrayImage_i,
    input  logic       start_i,
    output logic       dataAvailable_o,
    output logic       valid_o,
    output logic [7:0] ProcessedImagePixel_o
);

    localparam int N_IN  = IMG_X_SIZE * IMG_Y_SIZE;
    localparam int OUT_X = IMG_X_SIZE - 2;
    localparam int OUT_Y = IMG_Y_SIZE - 2;
    localparam int AW    = $clog2(N_IN);

    if (KX_SIZE != 3 || KY_SIZE != 3) begin : g_bad_kernel
        $error("sobel: only 3x3 kernels are supported");
    end
    if (IMG_X_SIZE < 3 || IMG_Y_SIZE < 3) begin : g_bad_image
        $error("sobel: image must be at least 3x3");
    end

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   row_q, row_d;
    logic [AW-1:0]   col_q, col_d;
    logic            da_q, da_d;
    logic            valid_q, valid_d;
    logic [7:0]      pix_q, pix_d;
    logic            we_s;
    logic [7:0]      buf_q [N_IN];
    logic [8:0][7:0] win_s;
    logic [7:0]      mag_s;

    // Gather the 3x3 window whose top-left corner is (row_q, col_q).
    always_comb begin
        win_s = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_s[i*3+j] = buf_q[AW'((int'(row_q) + i) * IMG_X_SIZE + int'(col_q) + j)];
            end
        end
    end

    sobel_kernel3x3 u_kernel (
        .win_i (win_s),
        .mag_o (mag_s)
    );

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        da_d    = 1'b0;
        valid_d = 1'b0;
        pix_d   = pix_q;
        we_s    = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                row_d = '0;
                col_d = '0;
                if (start_i) begin
                    state_d = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (!start_i) begin
                    state_d = LOAD;
                end else begin
                    state_d = ARMED;
                end
            end
            LOAD: begin
                we_s = 1'b1;
                if (idx_q == AW'(N_IN - 1)) begin
                    idx_d   = '0;
                    da_d    = 1'b1;
                    state_d = AVAIL;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            AVAIL: begin
                state_d = COMPUTE;
            end
            COMPUTE: begin
                valid_d = 1'b1;
                pix_d   = mag_s;
                if (col_q == AW'(OUT_X - 1)) begin
                    col_d = '0;
                    if (row_q == AW'(OUT_Y - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + AW'(1);
                    end
                end else begin
                    col_d = col_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            da_q    <= 1'b0;
            valid_q <= 1'b0;
            pix_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            da_q    <= da_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
        end
    end

    // Frame buffer capture; contents need no reset since every load overwrites it.
    always_ff @(posedge clk_i) begin
        if (we_s) begin
            buf_q[idx_q] <= GrayImage_i;
        end
    end

    assign dataAvailable_o       = da_q;
    assign valid_o               = valid_q;
    assign ProcessedImagePixel_o = pix_q;

endmodule

// File: tb/tb_sobel.sv
// Directed bench for the Sobel core: 3x3 and 4x4 instances, hand-computed results.
module tb_sobel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start3, start4;
    logic [7:0] pix;
    logic       da3, v3, da4, v4;
    logic [7:0] o3, o4;
    logic       sel4;
    logic       da_s, v_s;
    logic [7:0] o_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] img  [16];
    logic [7:0] expv [4];

    always #5 clk = ~clk;

    sobel #(.KX_SIZE(3), .KY_SIZE(3), .IMG_X_SIZE(3), .IMG_Y_SIZE(3)) u_sobel3 (
        .clk_i(clk), .rst_i(rst_n), .GrayImage_i(pix), .start_i(start3),
        .dataAvailable_o(da3), .valid_o(v3), .ProcessedImagePixel_o(o3)
    );

    sobel #(.KX_SIZE(3), .KY_SIZE(3), .IMG_X_SIZE(4), .IMG_Y_SIZE(4)) u_sobel4 (
        .clk_i(clk), .rst_i(rst_n), .GrayImage_i(pix), .start_i(start4),
        .dataAvailable_o(da4), .valid_o(v4), .ProcessedImagePixel_o(o4)
    );

    assign da_s = sel4 ? da4 : da3;
    assign v_s  = sel4 ? v4  : v3;
    assign o_s  = sel4 ? o4  : o3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit is4, input logic v);
        if (is4) start4 = v;
        else     start3 = v;
    endtask

    // Start handshake, load the frame from img[], then watch outputs for a bounded window.
    task automatic run_frame(input string tag, input bit is4, input int n_out, input bit tog);
        int n_in;
        int nv;
        int nda;
        n_in = is4 ? 16 : 9;
        nv   = 0;
        nda  = 0;
        sel4 = is4;
        @(posedge clk); #1;
        set_start(is4, 1'b1);
        @(posedge clk); #1;
        set_start(is4, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < n_in; k++) begin
            pix = img[k];
            @(posedge clk); #1;
            if (k < n_in - 1 && da_s) nda++;
        end
        check_eq({tag, "_da_pulse"}, 32'(da_s), 32'd1);
        check_eq({tag, "_da_early"}, 32'(nda), 32'd0);
        for (int m = 0; m < 40; m++) begin
            @(posedge clk); #1;
            if (tog && m < 3) set_start(is4, (m % 2) == 0);
            else              set_start(is4, 1'b0);
            if (da_s) nda++;
            if (v_s) begin
                if (nv < 4) check_eq($sformatf("%s_out%0d", tag, nv), 32'(o_s), 32'(expv[nv]));
                nv++;
            end
        end
        check_eq({tag, "_n_valid"}, 32'(nv), 32'(n_out));
        check_eq({tag, "_da_extra"}, 32'(nda), 32'd0);
        check_eq({tag, "_hold"}, 32'(o_s), 32'(expv[n_out-1]));
    endtask

    initial begin
        rst_n  = 1'b1;
        start3 = 1'b0;
        start4 = 1'b0;
        pix    = 8'd0;
        sel4   = 1'b0;
        #2 rst_n = 1'b0;
        #20;
        check_eq("rst_da3", 32'(da3), 32'd0);
        check_eq("rst_v3",  32'(v3),  32'd0);
        check_eq("rst_o3",  32'(o3),  32'd0);
        check_eq("rst_da4", 32'(da4), 32'd0);
        check_eq("rst_v4",  32'(v4),  32'd0);
        check_eq("rst_o4",  32'(o4),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Ramp 10..90: Gx=80, Gy=240 -> 320 clamps to 255.
        for (int k = 0; k < 9; k++) img[k] = 8'(10 * (k + 1));
        expv[0] = 8'd255;
        run_frame("ramp", 1'b0, 1, 1'b0);

        // Uniform 50 -> 0.
        for (int k = 0; k < 9; k++) img[k] = 8'd50;
        expv[0] = 8'd0;
        run_frame("flat", 1'b0, 1, 1'b0);

        // Rows 0,1,2 -> Gx=8, Gy=0.
        for (int k = 0; k < 9; k++) img[k] = 8'(k % 3);
        expv[0] = 8'd8;
        run_frame("hgrad", 1'b0, 1, 1'b0);

        // Transposed -> Gy=8.
        for (int k = 0; k < 9; k++) img[k] = 8'(k / 3);
        expv[0] = 8'd8;
        run_frame("vgrad", 1'b0, 1, 1'b0);

        // Rows 3,2,1 -> Gx=-8, |Gx|=8.
        for (int k = 0; k < 9; k++) img[k] = 8'(3 - (k % 3));
        expv[0] = 8'd8;
        run_frame("neg", 1'b0, 1, 1'b0);

        // Only p21=10 -> Gy=20.
        for (int k = 0; k < 9; k++) img[k] = 8'd0;
        img[7] = 8'd10;
        expv[0] = 8'd20;
        run_frame("p21", 1'b0, 1, 1'b0);

        // 4x4 rows 0..3 -> four outputs of 8.
        for (int k = 0; k < 16; k++) img[k] = 8'(k % 4);
        for (int k = 0; k < 4; k++) expv[k] = 8'd8;
        run_frame("x4ramp", 1'b1, 4, 1'b0);

        // 4x4 impulse at (1,1)=10 -> 0, 20, 20, 20.
        for (int k = 0; k < 16; k++) img[k] = 8'd0;
        img[5] = 8'd10;
        expv[0] = 8'd0;
        expv[1] = 8'd20;
        expv[2] = 8'd20;
        expv[3] = 8'd20;
        run_frame("x4imp", 1'b1, 4, 1'b0);

        // start_i toggled during COMPUTE must be ignored.
        for (int k = 0; k < 16; k++) img[k] = 8'(k % 4);
        for (int k = 0; k < 4; k++) expv[k] = 8'd8;
        run_frame("x4tog", 1'b1, 4, 1'b1);

        // Reset in the middle of a 3x3 load (last 3x3 output was 20).
        sel4 = 1'b0;
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            pix = 8'(k + 1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_da", 32'(da3), 32'd0);
        check_eq("midrst_v",  32'(v3),  32'd0);
        check_eq("midrst_o",  32'(o3),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Full frame after the aborted one.
        for (int k = 0; k < 9; k++) img[k] = 8'(10 * (k + 1));
        expv[0] = 8'd255;
        run_frame("after_rst", 1'b0, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
